// File: rtl/rr_shared_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit register between N requesters.
// Sequence per write: IDLE -> GRANT (load) -> ACK (one-cycle pulse).
module rr_shared_reg_arbiter #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   wdata,
    input  logic             sync_clear,
    output logic [N-1:0]     grant,
    output logic [N-1:0]     ack,
    output logic [W-1:0]     q,
    output logic             busy,
    output logic [IDW-1:0]   last_id
);

    typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

    state_t         state_q;
    logic [N-1:0]   grant_q;
    logic [N-1:0]   ack_q;
    logic [W-1:0]   q_q;
    logic           busy_q;
    logic [IDW-1:0] last_id_q;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] sel_q;

    logic [IDW-1:0] pick;
    logic [N-1:0]   pick_oh;
    logic           found;
    logic [W-1:0]   lane;
    logic           still_req;

    // Scan above the pointer first, then wrap to 0..ptr (ptr itself last).
    always_comb begin
        pick    = '0;
        pick_oh = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i > int'(ptr_q))) begin
                found      = 1'b1;
                pick       = IDW'(i);
                pick_oh[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i <= int'(ptr_q))) begin
                found      = 1'b1;
                pick       = IDW'(i);
                pick_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        lane = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) lane = wdata[i*W +: W];
        end
        still_req = |(req & grant_q);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ack_q     <= '0;
            q_q       <= '0;
            busy_q    <= 1'b0;
            last_id_q <= '0;
            ptr_q     <= IDW'(N - 1);
            sel_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ack_q <= '0;
                    if (found) begin
                        grant_q <= pick_oh;
                        sel_q   <= pick;
                        busy_q  <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    grant_q <= '0;
                    if (still_req) begin
                        q_q       <= lane;
                        ack_q     <= grant_q;
                        ptr_q     <= sel_q;
                        last_id_q <= sel_q;
                        state_q   <= ACK;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ACK: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    grant_q <= '0;
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
            // Zeroing wins over a same-edge load; the handshake still completes.
            if (sync_clear) q_q <= '0;
        end
    end

    assign grant   = grant_q;
    assign ack     = ack_q;
    assign q       = q_q;
    assign busy    = busy_q;
    assign last_id = last_id_q;

endmodule

// File: tb/tb_rr_shared_reg_arbiter.sv
// Testbench for rr_shared_reg_arbiter: directed scenarios plus a
// randomized run against a transaction-level round-robin model.
module tb_rr_shared_reg_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic             clock = 1'b0;
    logic             clear;
    logic [N-1:0]     req;
    logic [N*W-1:0]   wdata;
    logic             sync_clear;
    logic [N-1:0]     grant;
    logic [N-1:0]     ack;
    logic [W-1:0]     q;
    logic             busy;
    logic [IDW-1:0]   last_id;

    int n_checks = 0;
    int n_fail   = 0;

    rr_shared_reg_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
        .clock      (clock),
        .clear      (clear),
        .req        (req),
        .wdata      (wdata),
        .sync_clear (sync_clear),
        .grant      (grant),
        .ack        (ack),
        .q          (q),
        .busy       (busy),
        .last_id    (last_id)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!clear) begin
            n_checks++;
            if ((grant != 0 && ack != 0) || !$onehot0(grant) || !$onehot0(ack)) begin
                n_fail++;
                $display("FAIL invariant grant=%b ack=%b", grant, ack);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic apply_clear();
        clear      = 1'b1;
        req        = '0;
        sync_clear = 1'b0;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1; req = '0; wdata = '0; sync_clear = 1'b0;
        #2;
        n_checks++;
        if (grant !== 0 || ack !== 0 || q !== 0 || busy !== 0 || last_id !== 0) begin
            n_fail++;
            $display("FAIL reset_async g=%b a=%b q=%h b=%b id=%0d exp all 0",
                     grant, ack, q, busy, last_id);
        end
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        n_checks++;
        if (grant !== 0 || busy !== 0 || q !== 0) begin
            n_fail++;
            $display("FAIL reset_idle g=%b q=%h b=%b exp 0", grant, q, busy);
        end
    endtask

    task automatic test_single();
        wdata[7:0] = 8'hA5;
        req = 4'b0001;
        @(negedge clock);
        n_checks++;
        if (grant !== 4'b0001 || busy !== 1'b1 || ack !== 0) begin
            n_fail++;
            $display("FAIL single_grant g=%b b=%b a=%b exp 0001/1/0000", grant, busy, ack);
        end
        @(negedge clock);
        n_checks++;
        if (q !== 8'hA5 || ack !== 4'b0001 || last_id !== 0 || grant !== 0) begin
            n_fail++;
            $display("FAIL single_ack q=%h a=%b id=%0d g=%b exp a5/0001/0/0000",
                     q, ack, last_id, grant);
        end
        req = '0;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || ack !== 0) begin
            n_fail++;
            $display("FAIL single_done b=%b a=%b exp 0/0000", busy, ack);
        end
    endtask

    task automatic test_all_four();
        int order[$];
        int t_ack[$];
        apply_clear();
        wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1111;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clock);
            for (int k = 0; k < N; k++) begin
                if (ack[k]) begin
                    order.push_back(k);
                    t_ack.push_back(cyc);
                    n_checks++;
                    if (q !== 8'(8'h10 + k)) begin
                        n_fail++;
                        $display("FAIL all4_q req%0d q=%h exp %h", k, q, 8'(8'h10 + k));
                    end
                    req[k] = 1'b0;
                end
            end
        end
        n_checks++;
        if (order.size() != 4) begin
            n_fail++;
            $display("FAIL all4_count got=%0d exp 4", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            n_checks++;
            if (order[i] != i) begin
                n_fail++;
                $display("FAIL all4_order pos%0d got=%0d exp %0d", i, order[i], i);
            end
            if (i > 0) begin
                n_checks++;
                if (t_ack[i] - t_ack[i-1] != 3) begin
                    n_fail++;
                    $display("FAIL all4_spacing pos%0d got=%0d exp 3", i, t_ack[i] - t_ack[i-1]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int order[$];
        wdata = {8'h23, 8'h00, 8'h00, 8'h20};
        req = 4'b1001;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clock);
            for (int k = 0; k < N; k++) begin
                if (ack[k]) begin
                    order.push_back(k);
                    req[k] = 1'b0;
                end
            end
        end
        n_checks++;
        if (order.size() != 2 || order[0] != 0 || order[1] != 3) begin
            n_fail++;
            $display("FAIL wrap_order got n=%0d first=%0d exp 0 then 3",
                     order.size(), (order.size() > 0) ? order[0] : -1);
        end
        n_checks++;
        if (q !== 8'h23 || last_id !== 3) begin
            n_fail++;
            $display("FAIL wrap_final q=%h id=%0d exp 23/3", q, last_id);
        end
    endtask

    task automatic test_abandon();
        wdata[23:16] = 8'h77;
        req = 4'b0100;
        @(negedge clock);
        n_checks++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL abandon_grant g=%b exp 0100", grant);
        end
        req = '0;
        @(negedge clock);
        n_checks++;
        if (ack !== 0 || q !== 8'h23 || busy !== 0 || grant !== 0 || last_id !== 3) begin
            n_fail++;
            $display("FAIL abandon_noack a=%b q=%h b=%b g=%b id=%0d exp 0000/23/0/0000/3",
                     ack, q, busy, grant, last_id);
        end
        wdata[15:8] = 8'h31;
        req = 4'b0110;
        @(negedge clock);
        n_checks++;
        if (grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL abandon_next g=%b exp 0010", grant);
        end
        @(negedge clock);
        n_checks++;
        if (ack !== 4'b0010 || q !== 8'h31) begin
            n_fail++;
            $display("FAIL abandon_next_ack a=%b q=%h exp 0010/31", ack, q);
        end
        req = '0;
        @(negedge clock);
    endtask

    task automatic test_sync_clear();
        wdata[15:8] = 8'hFF;
        req = 4'b0010;
        @(negedge clock);
        n_checks++;
        if (grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL sclr_grant g=%b exp 0010", grant);
        end
        sync_clear = 1'b1;
        @(negedge clock);
        n_checks++;
        if (q !== 8'h00 || ack !== 4'b0010 || last_id !== 1) begin
            n_fail++;
            $display("FAIL sclr_ack q=%h a=%b id=%0d exp 00/0010/1", q, ack, last_id);
        end
        sync_clear = 1'b0;
        req = '0;
        @(negedge clock);
    endtask

    task automatic test_clear_mid_ack();
        wdata[7:0] = 8'h3C;
        req = 4'b0001;
        @(negedge clock);
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL clrmid_grant g=%b exp 0001", grant);
        end
        @(negedge clock);
        n_checks++;
        if (q !== 8'h3C || ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL clrmid_ack q=%h a=%b exp 3c/0001", q, ack);
        end
        #2 clear = 1'b1;
        #1;
        n_checks++;
        if (q !== 0 || grant !== 0 || ack !== 0 || busy !== 0 || last_id !== 0) begin
            n_fail++;
            $display("FAIL clrmid_async q=%h g=%b a=%b b=%b id=%0d exp all 0",
                     q, grant, ack, busy, last_id);
        end
        req = '0;
        @(negedge clock);
        clear = 1'b0;
        wdata[23:16] = 8'h5A;
        req = 4'b0100;
        @(negedge clock);
        n_checks++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL clrmid_next_grant g=%b exp 0100", grant);
        end
        @(negedge clock);
        n_checks++;
        if (ack !== 4'b0100 || q !== 8'h5A || last_id !== 2) begin
            n_fail++;
            $display("FAIL clrmid_next_ack a=%b q=%h id=%0d exp 0100/5a/2", ack, q, last_id);
        end
        req = '0;
        @(negedge clock);
    endtask

    task automatic test_random();
        int m_ptr;
        int m_last;
        logic [W-1:0] m_q;
        logic [N-1:0] r;
        logic [N-1:0] exp_ack;
        int k;
        bit abandon;
        bit sc;
        apply_clear();
        m_ptr = N - 1; m_last = 0; m_q = '0;
        repeat (60) begin
            r = N'($urandom_range(1, (1 << N) - 1));
            wdata = (N*W)'({$urandom, $urandom});
            req = r;
            k = -1;
            for (int off = 1; off <= N; off++) begin
                if (k < 0 && r[(m_ptr + off) % N]) k = (m_ptr + off) % N;
            end
            @(negedge clock);
            n_checks++;
            if (grant !== N'(1 << k) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd_grant req=%b g=%b b=%b exp %b/1", r, grant, busy, N'(1 << k));
            end
            abandon = ($urandom_range(0, 3) == 0);
            sc = ($urandom_range(0, 3) == 0);
            sync_clear = sc;
            if (abandon) req[k] = 1'b0;
            exp_ack = '0;
            if (!abandon) begin
                m_q = wdata[k*W +: W];
                m_ptr = k;
                m_last = k;
                exp_ack = N'(1 << k);
            end
            if (sc) m_q = '0;
            @(negedge clock);
            sync_clear = 1'b0;
            n_checks++;
            if (ack !== exp_ack || q !== m_q || last_id !== IDW'(m_last) || grant !== 0) begin
                n_fail++;
                $display("FAIL rnd_ack a=%b q=%h id=%0d g=%b exp %b/%h/%0d/0000",
                         ack, q, last_id, grant, exp_ack, m_q, m_last);
            end
            if (!abandon) begin
                req[k] = 1'b0;
                @(negedge clock);
                n_checks++;
                if (busy !== 1'b0 || ack !== 0) begin
                    n_fail++;
                    $display("FAIL rnd_idle b=%b a=%b exp 0/0000", busy, ack);
                end
            end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_abandon();
        test_sync_clear();
        test_clear_mid_ack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
